// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FAULT  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// Combinational ALU operand bypass select for one Execute source register.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] sel_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m_i && (rd_m_i != REG_X0) && (rd_m_i == rs_i);
  assign hit_w = reg_write_w_i && (rd_w_i != REG_X0) && (rd_w_i == rs_i);

  // The younger result in Memory shadows an older write of the same register.
  always_comb begin
    sel_o = FWD_RF;
    if (hit_m) begin
      sel_o = FWD_MEM;
    end else if (hit_w) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipe: stalls, flushes, forwarding, memory timeout.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_count performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             mem_read_E,
  input  logic             pc_src_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_write_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_write_W,
  input  logic             mem_busy,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       forward_a_E,
  output logic [1:0]       forward_b_E,
  output logic             fault
`ifdef HAZARD_PERF_EN
  ,
  output logic [WIDTH-1:0] stall_cycles,
  output logic [WIDTH-1:0] flush_count
`endif
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  hz_state_t       state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic [CntW-1:0] wait_inc;
  logic            started_q;
  logic            load_use;
  logic            frozen;

  assign load_use = mem_read_E && (rd_E != REG_X0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign frozen   = (state_q == FAULT) || mem_busy;
  assign wait_inc = wait_q + 1'b1;
  assign fault    = (state_q == FAULT);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN, FREEZE: begin
        if (mem_busy) begin
          wait_d  = wait_inc;
          state_d = (wait_inc >= CntW'(MAX_WAIT)) ? FAULT : FREEZE;
        end else begin
          wait_d  = '0;
          state_d = RUN;
        end
      end
      FAULT:   state_d = FAULT;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      started_q <= 1'b1;
    end
  end

  // Outputs stay quiet for the first cycle out of reset so the PC can take its reset load.
  // A busy memory overrides everything; a taken branch beats a load-use bubble.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (started_q) begin
      if (frozen) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
      end else if (pc_src_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  forward_unit u_fwd_a (
    .rs_i          (rs1_E),
    .rd_m_i        (rd_M),
    .reg_write_m_i (reg_write_M),
    .rd_w_i        (rd_W),
    .reg_write_w_i (reg_write_W),
    .sel_o         (forward_a_E)
  );

  forward_unit u_fwd_b (
    .rs_i          (rs2_E),
    .rd_m_i        (rd_M),
    .reg_write_m_i (reg_write_M),
    .rd_w_i        (rd_W),
    .reg_write_w_i (reg_write_W),
    .sel_o         (forward_b_E)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_F && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush_D && !(&flush_count)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_hazard_ctrl;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MAX_WAIT = 16;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       mem_read_E, pc_src_E, reg_write_M, reg_write_W, mem_busy;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, fault;
  logic [1:0] forward_a_E, forward_b_E;
`ifdef HAZARD_PERF_EN
  logic [WIDTH-1:0] stall_cycles, flush_count;
`endif

  int n_checks;
  int n_errors;

  hazard_ctrl #(
    .WIDTH    (WIDTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_D        (rs1_D),
    .rs2_D        (rs2_D),
    .rs1_E        (rs1_E),
    .rs2_E        (rs2_E),
    .rd_E         (rd_E),
    .mem_read_E   (mem_read_E),
    .pc_src_E     (pc_src_E),
    .rd_M         (rd_M),
    .reg_write_M  (reg_write_M),
    .rd_W         (rd_W),
    .reg_write_W  (reg_write_W),
    .mem_busy     (mem_busy),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .stall_E      (stall_E),
    .stall_M      (stall_M),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .forward_a_E  (forward_a_E),
    .forward_b_E  (forward_b_E),
    .fault        (fault)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_started;   // at least one clock edge since reset release
  int m_busy_run;  // consecutive busy cycles seen so far
  bit m_fault;
  int m_stalls;
  int m_flushes;

  logic       lu, frz, active;
  logic       exp_stall_fd, exp_stall_em, exp_flush_d, exp_flush_e;
  logic [1:0] exp_fa, exp_fb;

  function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic wm, input logic [4:0] rdw,
                                           input logic ww);
    if (rs != 5'd0 && wm && rdm == rs) return 2'b10;
    if (rs != 5'd0 && ww && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    active       = rst && m_started;
    frz          = m_fault || mem_busy;
    lu           = mem_read_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
    exp_stall_fd = active && (frz || (lu && !pc_src_E));
    exp_stall_em = active && frz;
    exp_flush_d  = active && !frz && pc_src_E;
    exp_flush_e  = active && !frz && (pc_src_E || lu);
    exp_fa       = fwd_model(rs1_E, rd_M, reg_write_M, rd_W, reg_write_W);
    exp_fb       = fwd_model(rs2_E, rd_M, reg_write_M, rd_W, reg_write_W);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_started  <= 1'b0;
      m_busy_run <= 0;
      m_fault    <= 1'b0;
      m_stalls   <= 0;
      m_flushes  <= 0;
    end else begin
      m_started <= 1'b1;
      if (!m_fault) begin
        if (mem_busy) begin
          m_busy_run <= m_busy_run + 1;
          if (m_busy_run + 1 >= int'(MAX_WAIT)) m_fault <= 1'b1;
        end else begin
          m_busy_run <= 0;
        end
      end
      if (exp_stall_fd) m_stalls <= m_stalls + 1;
      if (exp_flush_d) m_flushes <= m_flushes + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("m_stall_F", {31'd0, stall_F}, {31'd0, exp_stall_fd});
      check("m_stall_D", {31'd0, stall_D}, {31'd0, exp_stall_fd});
      check("m_stall_E", {31'd0, stall_E}, {31'd0, exp_stall_em});
      check("m_stall_M", {31'd0, stall_M}, {31'd0, exp_stall_em});
      check("m_flush_D", {31'd0, flush_D}, {31'd0, exp_flush_d});
      check("m_flush_E", {31'd0, flush_E}, {31'd0, exp_flush_e});
      check("m_fwd_a", {30'd0, forward_a_E}, {30'd0, exp_fa});
      check("m_fwd_b", {30'd0, forward_b_E}, {30'd0, exp_fb});
      check("m_fault", {31'd0, fault}, {31'd0, m_fault});
`ifdef HAZARD_PERF_EN
      check("m_stall_cycles", stall_cycles, m_stalls);
      check("m_flush_count", flush_count, m_flushes);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    mem_read_E = 0; pc_src_E = 0; reg_write_M = 0; reg_write_W = 0; mem_busy = 0;
  endtask

  task automatic chk_stalls(input string name, input logic v);
    check({name, "_sF"}, {31'd0, stall_F}, {31'd0, v});
    check({name, "_sD"}, {31'd0, stall_D}, {31'd0, v});
    check({name, "_sE"}, {31'd0, stall_E}, {31'd0, v});
    check({name, "_sM"}, {31'd0, stall_M}, {31'd0, v});
  endtask

  task automatic chk_flush(input string name, input logic d, input logic e);
    check({name, "_fD"}, {31'd0, flush_D}, {31'd0, d});
    check({name, "_fE"}, {31'd0, flush_E}, {31'd0, e});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    tick();  // skip the quiet first cycle
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    idle();
    pc_src_E = 1'b1;
    tick();
    mid();
    chk_stalls("rst", 1'b0);
    chk_flush("rst", 1'b0, 1'b0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fwd", {28'd0, forward_a_E, forward_b_E}, 32'd0);

    // First cycle after release stays quiet even with a branch pending.
    tick();
    rst = 1'b1;
    mid();
    chk_flush("first", 1'b0, 1'b0);
    tick();
    mid();
    chk_flush("branch", 1'b1, 1'b1);
    chk_stalls("branch", 1'b0);

    // Load-use on rs1, then MEM forward on operand A.
    tick();
    idle();
    mem_read_E = 1; rd_E = 5; rs1_D = 5;
    mid();
    check("lu_sF", {31'd0, stall_F}, 32'd1);
    check("lu_sD", {31'd0, stall_D}, 32'd1);
    check("lu_sE", {31'd0, stall_E}, 32'd0);
    chk_flush("lu", 1'b0, 1'b1);
    tick();
    idle();
    rd_M = 5; reg_write_M = 1; rs1_E = 5;
    mid();
    check("lu_next_sF", {31'd0, stall_F}, 32'd0);
    check("lu_fwd_a", {30'd0, forward_a_E}, 32'd2);

    // x0 never stalls; rs2 match does; branch wins over load-use.
    tick();
    idle();
    mem_read_E = 1; rd_E = 0; rs1_D = 0;
    mid();
    check("lu_x0", {31'd0, stall_F}, 32'd0);
    tick();
    rd_E = 9; rs2_D = 9; rs1_D = 3;
    mid();
    check("lu_rs2", {31'd0, stall_F}, 32'd1);
    tick();
    pc_src_E = 1;
    mid();
    check("lu_br_sF", {31'd0, stall_F}, 32'd0);
    chk_flush("lu_br", 1'b1, 1'b1);

    // Forwarding priority and x0.
    tick();
    idle();
    rd_M = 7; rd_W = 7; reg_write_M = 1; reg_write_W = 1; rs2_E = 7;
    mid();
    check("fwd_mem", {30'd0, forward_b_E}, 32'd2);
    tick();
    rd_M = 0;
    mid();
    check("fwd_wb", {30'd0, forward_b_E}, 32'd1);
    tick();
    rs2_E = 0;
    mid();
    check("fwd_x0", {30'd0, forward_b_E}, 32'd0);
    tick();
    rd_M = 7; reg_write_M = 0; rs2_E = 7;
    mid();
    check("fwd_nowm", {30'd0, forward_b_E}, 32'd1);

    // Three-cycle freeze with a held branch; flush lands after.
    tick();
    idle();
    pc_src_E = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk_stalls("frz", 1'b1);
      chk_flush("frz", 1'b0, 1'b0);
      tick();
    end
    mem_busy = 0;
    mid();
    chk_stalls("frz_end", 1'b0);
    chk_flush("frz_end", 1'b1, 1'b1);

    // One short of the limit does not fault.
    tick();
    idle();
    mem_busy = 1;
    repeat (MAX_WAIT - 1) tick();
    mem_busy = 0;
    mid();
    check("wait15_fault", {31'd0, fault}, 32'd0);
    chk_stalls("wait15_end", 1'b0);

    // Full timeout -> sticky fault, cleared only by reset.
    tick();
    mem_busy = 1;
    repeat (MAX_WAIT - 1) tick();
    mid();
    check("wait16_pre", {31'd0, fault}, 32'd0);
    tick();
    mem_busy = 0;
    pc_src_E = 1;
    mid();
    check("fault_set", {31'd0, fault}, 32'd1);
    chk_stalls("fault", 1'b1);
    chk_flush("fault", 1'b0, 1'b0);
    tick();
    tick();
    mid();
    check("fault_sticky", {31'd0, fault}, 32'd1);
    rst = 1'b0;
    #1;
    check("fault_rst", {31'd0, fault}, 32'd0);
    chk_stalls("fault_rst", 1'b0);
    tick();
    rst = 1'b1;
    idle();
    tick();

    // Reset mid-freeze clears the wait count.
    mem_busy = 1;
    repeat (10) tick();
    rst = 1'b0;
    #1;
    chk_stalls("mfrz_rst", 1'b0);
    tick();
    rst = 1'b1;
    tick();
    repeat (MAX_WAIT - 2) tick();
    mid();
    check("mfrz_nofault", {31'd0, fault}, 32'd0);
    tick();
    idle();
    tick();

`ifdef HAZARD_PERF_EN
    do_reset();
    mem_read_E = 1; rd_E = 5; rs1_D = 5;
    tick();
    idle();
    pc_src_E = 1; mem_busy = 1;
    repeat (3) tick();
    mem_busy = 0;
    tick();
    idle();
    mid();
    check("perf_stalls", stall_cycles, 32'd4);
    check("perf_flushes", flush_count, 32'd1);
    tick();
`else
    do_reset();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
